// File: rtl/apb_master_bridge.sv
// Purpose : valid/ready command -> APB3 SETUP/ACCESS requester with wait-state timeout and optional delayed read capture.
// Latency : accept@T, SETUP T+1, ACCESS T+2, rsp_valid T+3 (writes, or RD_SAMPLE_DLY=0) / T+4 (reads with RD_SAMPLE_DLY=1), plus wait states.
// Backpr. : one transaction in flight; cmd_ready_o only in IDLE; the response is held until rsp_ready_i.
//
// Ports
//   pclk_i, preset_n_i        clock, asynchronous active-low reset
//   cmd_*                     command channel in (valid/ready, write, addr, wdata)
//   rsp_*                     response channel out (valid/ready, rdata, err, tmo)
//   psel_o .. pwdata_o        APB requester outputs
//   pready_i, prdata_i,       APB completer inputs; tie pslverr_i low on slaves
//   pslverr_i                 that have no error output
module apb_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RD_SAMPLE_DLY  = 1
) (
    input  logic                  pclk_i,
    input  logic                  preset_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_tmo_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic                  pready_i,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pslverr_i
);

    localparam int              CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam bit              RD_DLY   = (RD_SAMPLE_DLY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_CAPT,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  r_tmo;

    // Gated with reset so the ready is low while reset is held, even though
    // the FSM already sits in IDLE.
    assign cmd_ready_o = (r_state == S_IDLE) && preset_n_i;

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;
    assign rsp_tmo_o   = r_tmo;
    assign psel_o      = r_psel;
    assign penable_o   = r_penable;
    assign pwrite_o    = r_pwrite;
    assign paddr_o     = r_paddr;
    assign pwdata_o    = r_pwdata;

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_pwrite <= cmd_write_i;
                        r_paddr  <= cmd_addr_i;
                        r_pwdata <= cmd_wdata_i;
                        r_psel   <= 1'b1;
                        // Fresh timeout budget for every transaction.
                        r_cnt    <= '0;
                        r_rdata  <= '0;
                        r_err    <= 1'b0;
                        r_tmo    <= 1'b0;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready_i) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_err     <= pslverr_i;
                        if (!r_pwrite && RD_DLY) begin
                            // Registered-read slaves: data shows up one cycle later.
                            r_state <= S_CAPT;
                        end else begin
                            r_rdata     <= (!r_pwrite && !pslverr_i) ? prdata_i : '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end else if (TMO_EN && (r_cnt == TMO_LAST)) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_err       <= 1'b1;
                        r_tmo       <= 1'b1;
                        r_rdata     <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CAPT: begin
                    // A slave error suppresses whatever data the slave drove.
                    r_rdata     <= r_err ? '0 : prdata_i;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
